// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  // Oversampling ratios the receiver is designed for.
  localparam int LEGAL_PRESCALE_8  = 8;
  localparam int LEGAL_PRESCALE_16 = 16;
  localparam int LEGAL_PRESCALE_32 = 32;

  // 2-of-3 vote used by the majority sampler.
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_bit_timer.sv
// Bit timer for the UART receiver: edge_cnt walks 0..prsc-1 inside a bit,
// bit_cnt counts completed bits of the current frame. Strobes fire one
// cycle before, at, and one cycle after the bit centre, plus at the bit end.
module uart_rx_bit_timer #(
  parameter int PRSC_W = 6,
  parameter int BIT_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic [PRSC_W-1:0] prsc,
  output logic              samp_early,
  output logic              samp_mid,
  output logic              samp_late,
  output logic              bit_done,
  output logic [BIT_W-1:0]  bit_cnt
);

  logic [PRSC_W-1:0] edge_cnt;
  logic [PRSC_W-1:0] half;

  assign half       = prsc >> 1;
  assign samp_early = en && (edge_cnt == half - PRSC_W'(1));
  assign samp_mid   = en && (edge_cnt == half);
  assign samp_late  = en && (edge_cnt == half + PRSC_W'(1));
  assign bit_done   = en && (edge_cnt == prsc - PRSC_W'(1));

  // Edge counter wraps at the bit end and advances the bit counter.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
    end else if (en) begin
      if (bit_done) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + BIT_W'(1);
      end else begin
        edge_cnt <= edge_cnt + PRSC_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start, DATA_WIDTH data bits LSB first, optional parity,
// one stop bit, oversampled at `prescale` clocks per bit.
// Build option UART_RX_MAJORITY_EN: 2-of-3 vote around the bit centre,
// decided one cycle after the centre; otherwise a single centre sample.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int PRSC_W     = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_in,
  input  logic [PRSC_W-1:0]     prescale,
  input  logic                  par_en,
  input  logic                  par_typ,
  output logic [DATA_WIDTH-1:0] p_data,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BIT_W = $clog2(DATA_WIDTH + 3);

  rx_state_t             state_q, state_d;
  logic [PRSC_W-1:0]     prsc_q;
  logic                  par_en_q, par_typ_q;
  logic [DATA_WIDTH-1:0] shift_q;
  logic                  perr_q, stop_q;
  logic                  tmr_en, tmr_clr, start_det;
  logic                  samp_early, samp_mid, samp_late, bit_done;
  logic [BIT_W-1:0]      bit_cnt;
  logic                  decide, bit_val;

  // The IDLE cycle that sees the line low is already edge 0 of the start bit.
  assign start_det = (state_q == IDLE) && !rx_in;
  assign tmr_en    = (state_q != IDLE) || !rx_in;

  uart_rx_bit_timer #(
    .PRSC_W (PRSC_W),
    .BIT_W  (BIT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .en         (tmr_en),
    .clr        (tmr_clr),
    .prsc       (prsc_q),
    .samp_early (samp_early),
    .samp_mid   (samp_mid),
    .samp_late  (samp_late),
    .bit_done   (bit_done),
    .bit_cnt    (bit_cnt)
  );

`ifdef UART_RX_MAJORITY_EN
  logic s_early_q, s_mid_q;

  // Hold the two leading votes until the third arrives.
  always_ff @(posedge clk) begin
    if (samp_early) s_early_q <= rx_in;
    if (samp_mid)   s_mid_q   <= rx_in;
  end

  assign decide  = samp_late;
  assign bit_val = majority3(s_early_q, s_mid_q, rx_in);
`else
  logic unused_strobes;
  assign unused_strobes = samp_early ^ samp_late;
  assign decide  = samp_mid;
  assign bit_val = rx_in;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and timer clear.
  always_comb begin
    state_d = state_q;
    tmr_clr = 1'b0;
    case (state_q)
      IDLE:   if (!rx_in) state_d = START;
      START: begin
        if (decide && bit_val) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end else if (bit_done) begin
          state_d = DATA;
        end
      end
      DATA:   if (bit_done && bit_cnt == BIT_W'(DATA_WIDTH)) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (bit_done) state_d = STOP;
      STOP: begin
        if (bit_done) begin
          state_d = IDLE;
          tmr_clr = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tmr_clr = 1'b1;
      end
    endcase
  end

  // Frame configuration is frozen at the start of each frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      prsc_q    <= PRSC_W'(LEGAL_PRESCALE_8);
      par_en_q  <= 1'b0;
      par_typ_q <= PAR_EVEN;
    end else if (start_det) begin
      prsc_q    <= prescale;
      par_en_q  <= par_en;
      par_typ_q <= par_typ;
    end
  end

  // Shift register, parity checker and stop-bit capture at each decision point.
  always_ff @(posedge clk) begin
    if (start_det) perr_q <= 1'b0;
    if (decide) begin
      case (state_q)
        DATA:    shift_q <= {bit_val, shift_q[DATA_WIDTH-1:1]};
        PARITY:  perr_q  <= bit_val != (^shift_q ^ (par_typ_q == PAR_ODD));
        STOP:    stop_q  <= bit_val;
        default: ;
      endcase
    end
  end

  // One-cycle result pulses on the cycle IDLE is re-entered.
  always_ff @(posedge clk) begin
    if (rst) begin
      p_data     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state_q == STOP && bit_done) begin
        par_err <= perr_q;
        stp_err <= !stop_q;
        if (!perr_q && stop_q) begin
          data_valid <= 1'b1;
          p_data     <= shift_q;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: the driver pushes the expected pulse,
// word and arrival cycle per frame; a monitor pops on every output pulse.
module tb_uart_rx;
  import uart_pkg::*;

  logic       clk = 1'b0;
  logic       rst, rx_in, par_en, par_typ;
  logic [5:0] prescale;
  logic [7:0] p_data;
  logic       data_valid, par_err, stp_err;

  typedef struct {
    logic       dv;
    logic       pe;
    logic       se;
    logic [7:0] data;
    int         when;
  } exp_t;

  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  logic [7:0] last_good = 8'h00;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_rx dut (
    .clk        (clk),
    .rst        (rst),
    .rx_in      (rx_in),
    .prescale   (prescale),
    .par_en     (par_en),
    .par_typ    (par_typ),
    .p_data     (p_data),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every output pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && (data_valid || par_err || stp_err)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_pulse: dv=%0b pe=%0b se=%0b at cycle %0d", data_valid, par_err, stp_err, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("data_valid", int'(data_valid), int'(e.dv));
        check("par_err", int'(par_err), int'(e.pe));
        check("stp_err", int'(stp_err), int'(e.se));
        check("p_data", int'(p_data), int'(e.data));
        check("latency_cycle", cyc, e.when);
      end
    end
  end

  // Drives one frame starting at the current negedge. glitch_bit inverts the
  // line for the single centre cycle of that frame bit; abort_bit pulses rst
  // at the start of that frame bit instead of finishing the frame.
  task automatic send_frame(input logic [7:0] data, input int p, input logic pen,
                            input logic ptyp, input logic bad_par, input logic stop_val,
                            input logic [7:0] rx_word, input int glitch_bit, input int abort_bit);
    logic bits [12];
    int   n;
    exp_t e;
    n = 10 + int'(pen);
    bits[0] = 1'b0;
    for (int i = 0; i < 8; i++) bits[i+1] = data[i];
    bits[9] = pen ? (^data ^ ptyp ^ bad_par) : stop_val;
    bits[n-1] = stop_val;
    prescale = 6'(p);
    par_en   = pen;
    par_typ  = ptyp;
    if (abort_bit < 0) begin
      e.pe = pen & bad_par;
      e.se = ~stop_val;
      e.dv = !e.pe && !e.se;
      if (e.dv) last_good = rx_word;
      e.data = last_good;
      e.when = cyc + n * p;
      sb.push_back(e);
    end
    for (int k = 0; k < n; k++) begin
      if (k == abort_bit) begin
        rst   = 1'b1;
        rx_in = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      for (int j = 0; j < p; j++) begin
        rx_in = (k == glitch_bit && j == p / 2) ? ~bits[k] : bits[k];
        @(negedge clk);
      end
      // Mid-frame configuration changes must be ignored by the receiver.
      if (k == 0) begin
        prescale = (p == 8) ? 6'd16 : 6'd8;
        par_en   = ~pen;
        par_typ  = ~ptyp;
      end
    end
    rx_in = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    rx_in    = 1'b1;
    prescale = 6'(LEGAL_PRESCALE_8);
    par_en   = 1'b0;
    par_typ  = PAR_EVEN;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_p_data", int'(p_data), 0);
    check("reset_data_valid", int'(data_valid), 0);
    check("reset_par_err", int'(par_err), 0);
    check("reset_stp_err", int'(stp_err), 0);
    repeat (3) @(negedge clk);

    // 1: 8x oversampling, no parity
    send_frame(8'hA5, LEGAL_PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8'hA5, -1, -1);
    repeat (5) @(negedge clk);

    // 2: odd parity, correct parity bit then wrong parity bit
    send_frame(8'h3C, LEGAL_PRESCALE_16, 1'b1, PAR_ODD, 1'b0, 1'b1, 8'h3C, -1, -1);
    repeat (5) @(negedge clk);
    send_frame(8'h3C, LEGAL_PRESCALE_16, 1'b1, PAR_ODD, 1'b1, 1'b1, 8'h00, -1, -1);
    repeat (5) @(negedge clk);

    // 3: stop bit sampled low
    send_frame(8'h5A, LEGAL_PRESCALE_8, 1'b0, PAR_EVEN, 1'b0, 1'b0, 8'h00, -1, -1);
    repeat (5) @(negedge clk);

    // 4: 3-cycle false start, then a real frame
    prescale = 6'(LEGAL_PRESCALE_16);
    par_en   = 1'b0;
    rx_in    = 1'b0;
    repeat (3) @(negedge clk);
    rx_in = 1'b1;
    repeat (40) @(negedge clk);
    send_frame(8'h81, LEGAL_PRESCALE_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8'h81, -1, -1);
    repeat (5) @(negedge clk);

    // 5: back-to-back frames at 32x, no idle gap
    send_frame(8'h00, LEGAL_PRESCALE_32, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8'h00, -1, -1);
    send_frame(8'hFF, LEGAL_PRESCALE_32, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8'hFF, -1, -1);
    repeat (5) @(negedge clk);

    // 6: reset at data bit 4 (frame bit 5), then a clean frame
    send_frame(8'h55, LEGAL_PRESCALE_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8'h55, -1, 5);
    check("midreset_p_data", int'(p_data), 0);
    check("midreset_data_valid", int'(data_valid), 0);
    check("midreset_par_err", int'(par_err), 0);
    check("midreset_stp_err", int'(stp_err), 0);
    last_good = 8'h00;
    repeat (20) @(negedge clk);
    send_frame(8'h33, LEGAL_PRESCALE_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8'h33, -1, -1);
    repeat (5) @(negedge clk);

    // 6b: one-cycle glitch at the centre of data bit 2 (0 -> 1)
`ifdef UART_RX_MAJORITY_EN
    send_frame(8'h33, LEGAL_PRESCALE_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8'h33, 3, -1);
`else
    send_frame(8'h33, LEGAL_PRESCALE_16, 1'b0, PAR_EVEN, 1'b0, 1'b1, 8'h37, 3, -1);
`endif

    for (int i = 0; i < 3000 && sb.size() != 0; i++) @(negedge clk);
    check("scoreboard_drained", sb.size(), 0);
    repeat (50) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
